// File: rtl/fifo_rd_pack_n.sv
// fifo_rd_pack_n: pops RATIO words from a source FIFO and packs them into one
// wide registered output word, with partial-word flush and output backpressure.
module fifo_rd_pack_n #(
  parameter int I_WIDTH = 64,
  parameter int RATIO = 2,
  parameter bit MSB_FIRST = 1,
  localparam int O_WIDTH = I_WIDTH*RATIO,
  localparam int CW = $clog2(RATIO+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [I_WIDTH-1:0] idata,
  input  logic               i_rdy,
  output logic               pop,
  output logic [O_WIDTH-1:0] odata,
  output logic               o_rdy,
  output logic [CW-1:0]      o_cnt,
  input  logic               pull,
  input  logic               flush
);
  logic [CW-1:0] r_slot;
  logic r_asm_full;
  logic [O_WIDTH-1:0] r_asm, w_asm;
  logic w_out_free, w_last, w_full_xfer, w_pop_xfer, w_flush_xfer, w_xfer;
  assign w_out_free = !o_rdy | pull;
  assign pop = i_rdy & !r_asm_full & !flush & !reset;
  assign w_last = r_slot == CW'(RATIO-1);
  assign w_full_xfer = r_asm_full & w_out_free;
  assign w_pop_xfer = pop & w_last & w_out_free;
  assign w_flush_xfer = flush & !r_asm_full & (r_slot != '0) & w_out_free;
  assign w_xfer = w_full_xfer | w_pop_xfer | w_flush_xfer;
  // Assembly with this cycle's popped word merged into the current slot
  always_comb begin
    w_asm = r_asm;
    for (int k = 0; k < RATIO; k++)
      if (pop && r_slot == CW'(k))
        w_asm[(MSB_FIRST ? RATIO-1-k : k)*I_WIDTH +: I_WIDTH] = idata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= '0;
      r_asm_full <= 1'b0;
      r_asm <= '0;
      odata <= '0;
      o_cnt <= '0;
      o_rdy <= 1'b0;
    end else begin
      o_rdy <= w_xfer | (o_rdy & !pull);
      if (w_xfer) begin
        odata <= w_pop_xfer ? w_asm : r_asm;
        o_cnt <= w_flush_xfer ? r_slot : CW'(RATIO);
        r_slot <= '0;
        r_asm <= '0;
        r_asm_full <= 1'b0;
      end else if (pop) begin
        r_asm <= w_asm;
        r_asm_full <= w_last;
        r_slot <= w_last ? r_slot : r_slot + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_pack_n.sv
// tb_fifo_rd_pack_n: directed checks of the packer in three configurations.
module tb_fifo_rd_pack_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int vecs = 0;
  int miss = 0;
  logic a_rst, a_irdy, a_pop, a_ordy, a_pull, a_flush;
  logic [63:0] a_idata;
  logic [127:0] a_odata;
  logic [1:0] a_ocnt;
  logic b_rst, b_irdy, b_pop, b_ordy, b_pull, b_flush;
  logic [63:0] b_idata;
  logic [255:0] b_odata;
  logic [2:0] b_ocnt;
  logic c_rst, c_irdy, c_pop, c_ordy, c_pull, c_flush;
  logic [63:0] c_idata;
  logic [255:0] c_odata;
  logic [2:0] c_ocnt;
  fifo_rd_pack_n #(.I_WIDTH(64), .RATIO(2), .MSB_FIRST(1)) u_a (
    .clk(clk), .reset(a_rst), .idata(a_idata), .i_rdy(a_irdy), .pop(a_pop),
    .odata(a_odata), .o_rdy(a_ordy), .o_cnt(a_ocnt), .pull(a_pull), .flush(a_flush));
  fifo_rd_pack_n #(.I_WIDTH(64), .RATIO(4), .MSB_FIRST(1)) u_b (
    .clk(clk), .reset(b_rst), .idata(b_idata), .i_rdy(b_irdy), .pop(b_pop),
    .odata(b_odata), .o_rdy(b_ordy), .o_cnt(b_ocnt), .pull(b_pull), .flush(b_flush));
  fifo_rd_pack_n #(.I_WIDTH(64), .RATIO(4), .MSB_FIRST(0)) u_c (
    .clk(clk), .reset(c_rst), .idata(c_idata), .i_rdy(c_irdy), .pop(c_pop),
    .odata(c_odata), .o_rdy(c_ordy), .o_cnt(c_ocnt), .pull(c_pull), .flush(c_flush));
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  localparam logic [63:0] A = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B = 64'h2222_2222_2222_2222;
  localparam logic [63:0] X = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] Y = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] Z = 64'hCCCC_0000_0000_000C;
  localparam logic [63:0] W = 64'hDDDD_0000_0000_000D;
  initial begin
    int words;
    {a_rst, b_rst, c_rst} = 3'b111;
    {a_irdy, a_pull, a_flush, b_irdy, b_pull, b_flush, c_irdy, c_pull, c_flush} = '0;
    a_idata = '0; b_idata = '0; c_idata = '0;
    cyc();
    cyc();
    chk("rst_a_odata", a_odata, '0);
    chk("rst_a_ordy", a_ordy, 0);
    chk("rst_a_ocnt", a_ocnt, 0);
    chk("rst_b_ordy", b_ordy, 0);
    a_irdy = 1; b_irdy = 1; c_irdy = 1;
    #1;
    chk("rst_a_pop", a_pop, 0);
    chk("rst_b_pop", b_pop, 0);
    chk("rst_c_pop", c_pop, 0);
    b_irdy = 0; c_irdy = 0;
    // two-word pack, MSB first
    a_rst = 0; a_pull = 1; a_idata = A;
    #1;
    chk("a_pop_A", a_pop, 1);
    cyc();
    a_idata = B;
    #1;
    chk("a_pop_B", a_pop, 1);
    chk("a_ordy_pre", a_ordy, 0);
    cyc();
    a_irdy = 0;
    chk("a_ordy", a_ordy, 1);
    chk("a_word", a_odata, {A, B});
    chk("a_cnt", a_ocnt, 2);
    cyc();
    chk("a_ordy_drop", a_ordy, 0);
    chk("a_hold_after_pull", a_odata, {A, B});
    a_pull = 0; a_flush = 1; a_irdy = 1;
    #1;
    chk("a_flush_pop", a_pop, 0);
    cyc();
    chk("a_flush_empty", a_ordy, 0);
    a_flush = 0;
    // backpressure: asm_full stall and release
    for (int i = 1; i <= 4; i++) begin
      a_idata = 64'(i);
      #1;
      chk("a_bp_pop", a_pop, 1);
      cyc();
    end
    a_idata = 64'd5;
    #1;
    chk("a_bp_stall", a_pop, 0);
    chk("a_bp_w0", a_odata, {64'd1, 64'd2});
    chk("a_bp_rdy", a_ordy, 1);
    cyc();
    chk("a_bp_stall2", a_pop, 0);
    chk("a_bp_hold", a_odata, {64'd1, 64'd2});
    a_pull = 1;
    cyc();
    a_pull = 0;
    chk("a_bp_w1", a_odata, {64'd3, 64'd4});
    chk("a_bp_rdy1", a_ordy, 1);
    chk("a_bp_cnt1", a_ocnt, 2);
    #1;
    chk("a_bp_resume", a_pop, 1);
    a_irdy = 0;
    // streaming, RATIO=4
    b_rst = 0; b_irdy = 1; b_pull = 1; words = 0;
    for (int i = 0; i < 40; i++) begin
      b_idata = 64'(i);
      cyc();
      chk("b_stream_rdy", b_ordy, (i % 4) == 3);
      if (i % 4 == 3) begin
        chk("b_stream_word", b_odata, {64'(i-3), 64'(i-2), 64'(i-1), 64'(i)});
        chk("b_stream_cnt", b_ocnt, 4);
        words++;
      end
    end
    chk("b_word_count", words, 10);
    // reset mid-assembly with o_rdy high
    b_pull = 0;
    b_idata = 64'd100;
    cyc();
    b_idata = 64'd101;
    cyc();
    chk("b_pre_rst_rdy", b_ordy, 1);
    b_rst = 1; b_irdy = 0;
    cyc();
    chk("b_rst_odata", b_odata, '0);
    chk("b_rst_ordy", b_ordy, 0);
    chk("b_rst_ocnt", b_ocnt, 0);
    b_rst = 0; b_irdy = 1;
    for (int i = 0; i < 4; i++) begin
      b_idata = 64'(200 + i);
      cyc();
    end
    b_irdy = 0;
    chk("b_post_rst_word", b_odata, {64'd200, 64'd201, 64'd202, 64'd203});
    chk("b_post_rst_cnt", b_ocnt, 4);
    chk("b_post_rst_rdy", b_ordy, 1);
    // LSB-first partial flush
    c_rst = 0; c_irdy = 1;
    c_idata = X; cyc();
    c_idata = Y; cyc();
    c_idata = Z; cyc();
    c_flush = 1;
    #1;
    chk("c_flush_pop", c_pop, 0);
    cyc();
    chk("c_flush_word", c_odata, {64'h0, Z, Y, X});
    chk("c_flush_cnt", c_ocnt, 3);
    chk("c_flush_rdy", c_ordy, 1);
    c_flush = 0; c_idata = W;
    cyc();
    c_flush = 1;
    cyc();
    chk("c_flush_blocked_rdy", c_ordy, 1);
    chk("c_flush_blocked_hold", c_odata, {64'h0, Z, Y, X});
    c_pull = 1;
    cyc();
    chk("c_flush2_word", c_odata, {64'h0, 64'h0, 64'h0, W});
    chk("c_flush2_cnt", c_ocnt, 1);
    chk("c_flush2_rdy", c_ordy, 1);
    cyc();
    chk("c_flush_slot0", c_ordy, 0);
    chk("c_cnt_hold", c_ocnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
